// File: rtl/arm7tdmi_exception_ctrl.sv
// arm7tdmi_exception_ctrl: fixed-priority exception arbiter producing the entry mode,
// vector, CPSR and SPSR of the highest pending exception, combinationally.
module arm7tdmi_exception_ctrl #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    input  logic        fiq,
    input  logic        swi,
    input  logic        undefined_instr,
    input  logic        prefetch_abort,
    input  logic        data_abort,
    input  logic [4:0]  current_mode,
    input  logic [31:0] current_cpsr,
    input  logic [31:0] current_pc,
    output logic        exception_taken,
    output logic [4:0]  exception_mode,
    output logic [31:0] exception_vector,
    output logic [31:0] exception_cpsr,
    output logic [31:0] exception_spsr,
    output logic [2:0]  exception_type
);
    localparam logic [4:0] MODE_FIQ = 5'h11, MODE_IRQ = 5'h12, MODE_SVC = 5'h13,
                           MODE_ABT = 5'h17, MODE_UND = 5'h1B;
    localparam logic [2:0] T_RST = 3'd0, T_UND = 3'd1, T_SWI = 3'd2, T_PABT = 3'd3,
                           T_DABT = 3'd4, T_IRQ = 3'd5, T_FIQ = 3'd6, T_NONE = 3'd7;

    logic       reset_pend_q, reset_pend_d;
    logic [2:0] sel;
    logic [4:0] tgt_mode;
    logic [7:0] vec_off;
    logic       f_new;
    logic       unused_pc;

    assign unused_pc = ^current_pc;

    always_ff @(posedge clk) begin
        if (rst) reset_pend_q <= 1'b1;
        else     reset_pend_q <= reset_pend_d;
    end

    always_comb begin
        reset_pend_d = 1'b0;
        // Masked interrupts drop out of arbitration entirely; lower sources are not held.
        sel = reset_pend_q                      ? T_RST  :
              data_abort                        ? T_DABT :
              (fiq && !current_cpsr[6])         ? T_FIQ  :
              (irq && !current_cpsr[7])         ? T_IRQ  :
              prefetch_abort                    ? T_PABT :
              undefined_instr                   ? T_UND  :
              swi                               ? T_SWI  : T_NONE;
        tgt_mode = (sel == T_RST || sel == T_SWI)   ? MODE_SVC :
                   (sel == T_UND)                   ? MODE_UND :
                   (sel == T_PABT || sel == T_DABT) ? MODE_ABT :
                   (sel == T_IRQ)                   ? MODE_IRQ :
                   (sel == T_FIQ)                   ? MODE_FIQ : current_mode;
        vec_off = (sel == T_UND)  ? 8'h04 :
                  (sel == T_SWI)  ? 8'h08 :
                  (sel == T_PABT) ? 8'h0C :
                  (sel == T_DABT) ? 8'h10 :
                  (sel == T_IRQ)  ? 8'h18 :
                  (sel == T_FIQ)  ? 8'h1C : 8'h00;
        f_new = (sel == T_RST || sel == T_FIQ) ? 1'b1 : current_cpsr[6];
        exception_taken  = (sel != T_NONE);
        exception_type   = sel;
        exception_mode   = tgt_mode;
        exception_vector = VECTOR_BASE + {24'h0, vec_off};
        exception_cpsr   = exception_taken ? {current_cpsr[31:8], 1'b1, f_new, 1'b0, tgt_mode}
                                           : current_cpsr;
        exception_spsr   = current_cpsr;
    end
endmodule

// File: tb/tb_arm7tdmi_exception_ctrl.sv
// tb_arm7tdmi_exception_ctrl: directed scoreboard bench for the exception arbiter.
module tb_arm7tdmi_exception_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        irq = 0, fiq = 0, swi = 0, undefined_instr = 0, prefetch_abort = 0, data_abort = 0;
    logic [4:0]  current_mode = 5'h1F;
    logic [31:0] current_cpsr = 32'h0000_001F, current_pc = 32'h0000_8000;
    logic        exception_taken;
    logic [4:0]  exception_mode;
    logic [31:0] exception_vector, exception_cpsr, exception_spsr;
    logic [2:0]  exception_type;

    typedef struct {
        string       tag;
        logic        taken;
        logic [4:0]  mode;
        logic [31:0] vec;
        logic [31:0] cpsr;
        logic [31:0] spsr;
        logic [2:0]  typ;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, passed = 0;

    arm7tdmi_exception_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .fiq(fiq), .swi(swi),
        .undefined_instr(undefined_instr), .prefetch_abort(prefetch_abort),
        .data_abort(data_abort), .current_mode(current_mode), .current_cpsr(current_cpsr),
        .current_pc(current_pc), .exception_taken(exception_taken),
        .exception_mode(exception_mode), .exception_vector(exception_vector),
        .exception_cpsr(exception_cpsr), .exception_spsr(exception_spsr),
        .exception_type(exception_type)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic da, input logic pa, input logic ud, input logic sw,
                         input logic fq, input logic iq, input logic [31:0] cpsr);
        data_abort = da; prefetch_abort = pa; undefined_instr = ud; swi = sw;
        fiq = fq; irq = iq; current_cpsr = cpsr;
    endtask

    task automatic expect_out(input string tag, input logic tk, input logic [4:0] md,
                              input logic [31:0] vc, input logic [31:0] cp,
                              input logic [31:0] sp, input logic [2:0] ty);
        exp_t e;
        e.tag = tag; e.taken = tk; e.mode = md; e.vec = vc; e.cpsr = cp; e.spsr = sp; e.typ = ty;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_taken"}, {31'h0, exception_taken}, {31'h0, e.taken});
            chk({e.tag, "_mode"},  {27'h0, exception_mode},  {27'h0, e.mode});
            chk({e.tag, "_vec"},   exception_vector,         e.vec);
            chk({e.tag, "_cpsr"},  exception_cpsr,           e.cpsr);
            chk({e.tag, "_spsr"},  exception_spsr,           e.spsr);
            chk({e.tag, "_type"},  {29'h0, exception_type},  {29'h0, e.typ});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick();
        expect_out("rst_held", 1, 5'h13, 32'h00, 32'h0000_00D3, 32'h0000_001F, 3'd0);
        check_out();
        rst = 1'b0;
        expect_out("rst_release", 1, 5'h13, 32'h00, 32'h0000_00D3, 32'h0000_001F, 3'd0);
        check_out();
        tick();
        expect_out("idle", 0, 5'h1F, 32'h00, 32'h0000_001F, 32'h0000_001F, 3'd7);
        check_out();
        tick();
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'h0000_001F);
        expect_out("dabt", 1, 5'h17, 32'h10, 32'h0000_0097, 32'h0000_001F, 3'd4);
        check_out();
        tick();
        drive(0, 1, 0, 0, 0, 0, 32'h0000_001F);
        expect_out("pabt", 1, 5'h17, 32'h0C, 32'h0000_0097, 32'h0000_001F, 3'd3);
        check_out();
        tick();
        drive(1, 0, 0, 0, 1, 1, 32'h0000_001F);
        expect_out("dabt_over_fiq", 1, 5'h17, 32'h10, 32'h0000_0097, 32'h0000_001F, 3'd4);
        check_out();
        tick();
        drive(0, 0, 0, 0, 1, 1, 32'h0000_001F);
        expect_out("fiq_over_irq", 1, 5'h11, 32'h1C, 32'h0000_00D1, 32'h0000_001F, 3'd6);
        check_out();
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'h6000_001F);
        expect_out("dabt_flags", 1, 5'h17, 32'h10, 32'h6000_0097, 32'h6000_001F, 3'd4);
        check_out();
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h0000_00DF);
        expect_out("irq_masked", 0, 5'h1F, 32'h00, 32'h0000_00DF, 32'h0000_00DF, 3'd7);
        check_out();
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h0000_001F);
        expect_out("irq", 1, 5'h12, 32'h18, 32'h0000_0092, 32'h0000_001F, 3'd5);
        check_out();
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'h0000_005F);
        expect_out("fiq_masked", 0, 5'h1F, 32'h00, 32'h0000_005F, 32'h0000_005F, 3'd7);
        check_out();
        tick();
        drive(0, 0, 0, 0, 1, 1, 32'h0000_005F);
        expect_out("irq_fmask", 1, 5'h12, 32'h18, 32'h0000_00D2, 32'h0000_005F, 3'd5);
        check_out();
        tick();
        drive(0, 1, 1, 1, 1, 1, 32'h0000_00DF);
        expect_out("pabt_ints_masked", 1, 5'h17, 32'h0C, 32'h0000_00D7, 32'h0000_00DF, 3'd3);
        check_out();
        tick();
        drive(0, 0, 1, 1, 0, 0, 32'h0000_001F);
        expect_out("und_over_swi", 1, 5'h1B, 32'h04, 32'h0000_009B, 32'h0000_001F, 3'd1);
        check_out();
        tick();
        drive(0, 0, 0, 1, 0, 0, 32'h8000_003F);
        expect_out("swi_thumb", 1, 5'h13, 32'h08, 32'h8000_0093, 32'h8000_003F, 3'd2);
        check_out();
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'h0000_001F);
        rst = 1'b1;
        expect_out("rst_pre_edge", 1, 5'h17, 32'h10, 32'h0000_0097, 32'h0000_001F, 3'd4);
        check_out();
        tick();
        expect_out("rst_mid_exc", 1, 5'h13, 32'h00, 32'h0000_00D3, 32'h0000_001F, 3'd0);
        check_out();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0000_0010);
        current_mode = 5'h10;
        tick();
        expect_out("idle_usr", 0, 5'h10, 32'h00, 32'h0000_0010, 32'h0000_0010, 3'd7);
        check_out();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
